// File: rtl/mem_stage.sv
// Memory pipeline stage: buffers the execute result, runs one bus access per
// load/store with lane steering, load extension, alignment and timeout checks.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        mem_req_in,
    input  logic        mem_we_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [31:0] inst_in,
    input  logic [29:0] ip_in,
    input  logic [2:0]  wb_lines_in,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_addr,
    output logic [2:0]  wb_lines_out,
    output logic [29:0] ip_out,
    output logic [31:0] inst_out,
    output logic        align_fault,
    output logic        bus_timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, inst_q, load_q;
    logic [29:0] ip_q;
    logic [2:0]  wb_lines_q;
    logic        mem_req_q, mem_we_q;
    logic        align_fault_q, bus_timeout_q, load_done_q;
    logic [7:0]  cnt_q;

    logic        busy, capture, misalign_in, start, timeout_hit;
    logic [1:0]  in_size, size_q;
    logic [31:0] shifted, load_ext, lane_wdata;
    logic [3:0]  lane_be;

    assign in_size     = inst_in[13:12];
    assign misalign_in = (in_size == 2'd3)
                       || ((in_size == 2'd1) && addr_in[0])
                       || ((in_size == 2'd2) && (addr_in[1:0] != 2'b00));
    assign capture     = clk_en && (state_q == IDLE);
    assign start       = capture && mem_req_in && !misalign_in;
    assign timeout_hit = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // An ack arriving together with the last allowed cycle still completes normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = BUSY;
            BUSY: if (bus_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == BUSY);
        bus_req = busy;
        stall   = busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            inst_q     <= '0;
            ip_q       <= '0;
            wb_lines_q <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
        end else if (capture) begin
            addr_q     <= addr_in;
            wdata_q    <= wdata_in;
            inst_q     <= inst_in;
            ip_q       <= ip_in;
            wb_lines_q <= wb_lines_in;
            mem_req_q  <= mem_req_in;
            mem_we_q   <= mem_we_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_fault_q <= 1'b0;
            bus_timeout_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_q        <= '0;
            cnt_q         <= '0;
        end else if (capture) begin
            align_fault_q <= mem_req_in && misalign_in;
            bus_timeout_q <= 1'b0;
            load_done_q   <= 1'b0;
            cnt_q         <= '0;
        end else if (busy) begin
            if (bus_ack) begin
                load_q      <= bus_rdata;
                load_done_q <= !mem_we_q;
            end else begin
                cnt_q <= cnt_q + 8'd1;
                if (timeout_hit) bus_timeout_q <= 1'b1;
            end
        end
    end

    assign size_q  = inst_q[13:12];
    assign shifted = load_q >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = load_q;
        case (size_q)
            2'd0: load_ext = inst_q[14] ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = inst_q[14] ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = load_q;
        endcase
    end

    always_comb begin
        lane_wdata = '0;
        lane_be    = '0;
        case (size_q)
            2'd0: begin
                lane_wdata = {4{wdata_q[7:0]}};
                lane_be    = 4'b0001 << addr_q[1:0];
            end
            2'd1: begin
                lane_wdata = {2{wdata_q[15:0]}};
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                lane_wdata = wdata_q;
                lane_be    = 4'b1111;
            end
            default: begin
                lane_wdata = '0;
                lane_be    = '0;
            end
        endcase
    end

    assign bus_addr  = addr_q[31:2];
    assign bus_we    = mem_we_q;
    assign bus_wdata = busy ? lane_wdata : 32'd0;
    assign bus_be    = busy ? lane_be : 4'd0;

    assign wb_data      = (mem_req_q && load_done_q) ? load_ext : addr_q;
    assign rd_addr      = inst_q[25:21];
    assign ip_out       = ip_q;
    assign inst_out     = inst_q;
    assign wb_lines_out = (align_fault_q || bus_timeout_q) ? 3'd0 : wb_lines_q;
    assign align_fault  = align_fault_q;
    assign bus_timeout  = bus_timeout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed and random accesses compared
// against an arithmetic model of the stage's load/store behaviour.
module tb_mem_stage;

    localparam int TMO = 4;

    logic        clk, rst, clk_en, mem_req_in, mem_we_in;
    logic [31:0] addr_in, wdata_in, inst_in;
    logic [29:0] ip_in;
    logic [2:0]  wb_lines_in;
    logic        bus_req, bus_we, bus_ack, stall, align_fault, bus_timeout;
    logic [29:0] bus_addr, ip_out;
    logic [31:0] bus_wdata, bus_rdata, wb_data, inst_out;
    logic [3:0]  bus_be;
    logic [4:0]  rd_addr;
    logic [2:0]  wb_lines_out;

    int vectors = 0;
    int miscompares = 0;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .mem_req_in(mem_req_in), .mem_we_in(mem_we_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .inst_in(inst_in),
        .ip_in(ip_in), .wb_lines_in(wb_lines_in),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall(stall), .wb_data(wb_data), .rd_addr(rd_addr),
        .wb_lines_out(wb_lines_out), .ip_out(ip_out), .inst_out(inst_out),
        .align_fault(align_fault), .bus_timeout(bus_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic isMisaligned(input int size, input logic [31:0] a);
        if (size == 3) return 1'b1;
        return (a % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [3:0] expBe(input int size, input logic [31:0] a);
        longint ones;
        ones = (64'd1 << (1 << size)) - 1;
        return 4'(ones << (a % 4));
    endfunction

    function automatic logic [31:0] expWdata(input int size, input logic [31:0] d);
        if (size == 0) return (d & 32'hFF) * 32'h01010101;
        if (size == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] expLoad(input int size, input logic zext,
                                            input logic [31:0] a, input logic [31:0] rd);
        longint v;
        longint bits;
        bits = 64'(8 << size);
        v = longint'(rd >> (8 * (a % 4)));
        if (bits < 32) begin
            v = v & ((64'd1 << bits) - 1);
            if (!zext && ((v >> (bits - 1)) & 1) == 1) v = v - (64'd1 << bits);
        end
        return 32'(v);
    endfunction

    // One full transaction: capture, serve the bus, then check results and their persistence.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input int size,
                                 input logic zext, input logic we, input logic req,
                                 input int ackDelay, input logic [31:0] rdata);
        logic [31:0] inst;
        logic [29:0] ip;
        logic [2:0]  wbl;
        logic        mis, goesBus, acked, expAlign, expTo;
        logic [31:0] expWb;
        int          expBusy, busy;
        inst = $urandom;
        inst[13:12] = 2'(size);
        inst[14] = zext;
        ip = 30'($urandom);
        wbl = 3'($urandom);
        mis = isMisaligned(size, a);
        goesBus = req && !mis;
        acked = goesBus && ackDelay >= 1 && ackDelay <= TMO;
        expBusy = goesBus ? (acked ? ackDelay : TMO) : 0;
        expAlign = req && mis;
        expTo = goesBus && !acked;
        expWb = (acked && !we) ? expLoad(size, zext, a, rdata) : a;

        @(negedge clk);
        addr_in = a; wdata_in = wd; inst_in = inst; ip_in = ip; wb_lines_in = wbl;
        mem_req_in = req; mem_we_in = we; clk_en = 1'b1; bus_ack = 1'b0;
        @(negedge clk);
        clk_en = 1'b0;
        addr_in = $urandom; wdata_in = $urandom; inst_in = $urandom;
        mem_req_in = 1'($urandom); mem_we_in = 1'($urandom);

        if (goesBus) begin
            checkOutput("stall_busy", 32'(stall), 32'd1);
            checkOutput("bus_be", 32'(bus_be), 32'(expBe(size, a)));
            checkOutput("bus_we", 32'(bus_we), 32'(we));
            if (we) checkOutput("bus_wdata", bus_wdata, expWdata(size, wd));
        end
        busy = 0;
        for (int c = 0; c < 20 && bus_req; c++) begin
            busy++;
            checkOutput("bus_addr", 32'(bus_addr), 32'(a >> 2));
            if (busy == ackDelay) begin
                bus_ack = 1'b1;
                bus_rdata = rdata;
            end
            @(negedge clk);
            bus_ack = 1'b0;
            bus_rdata = $urandom;
        end
        checkOutput("busy_cycles", 32'(busy), 32'(expBusy));
        checkOutput("stall_idle", 32'(stall), 32'd0);

        for (int r = 0; r < 2; r++) begin
            checkOutput("wb_data", wb_data, expWb);
            checkOutput("align_fault", 32'(align_fault), 32'(expAlign));
            checkOutput("bus_timeout", 32'(bus_timeout), 32'(expTo));
            checkOutput("wb_lines", 32'(wb_lines_out), (expAlign || expTo) ? 32'd0 : 32'(wbl));
            checkOutput("rd_addr", 32'(rd_addr), 32'(inst[25:21]));
            checkOutput("ip_out", 32'(ip_out), 32'(ip));
            checkOutput("inst_out", inst_out, inst);
            if (r == 0) begin
                bus_ack = 1'b1;
                bus_rdata = $urandom;
                @(negedge clk);
                bus_ack = 1'b0;
                checkOutput("idle_ack_req", 32'(bus_req), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int size, dly;
        rst = 1'b1; clk_en = 1'b0; mem_req_in = 1'b0; mem_we_in = 1'b0;
        addr_in = '0; wdata_in = '0; inst_in = '0; ip_in = '0; wb_lines_in = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #12;
        checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_inst_out", inst_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'h100, 32'h0, 2, 1'b0, 1'b0, 1'b1, 3, 32'hDEADBEEF);
        applyStimulus(32'h103, 32'h0, 0, 1'b0, 1'b0, 1'b1, 2, 32'h80FFFFFF);
        applyStimulus(32'h103, 32'h0, 0, 1'b1, 1'b0, 1'b1, 1, 32'h80FFFFFF);
        applyStimulus(32'h22, 32'h1234ABCD, 1, 1'b0, 1'b1, 1'b1, 2, 32'h0);
        applyStimulus(32'h102, 32'h0, 2, 1'b0, 1'b0, 1'b1, 2, 32'h0);
        applyStimulus(32'h40, 32'h0, 2, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        applyStimulus(32'h44, 32'h0, 2, 1'b0, 1'b0, 1'b1, TMO, 32'h13579BDF);
        applyStimulus(32'hCAFE0001, 32'h0, 3, 1'b0, 1'b0, 1'b0, 0, 32'h0);

        // Reset pulsed asynchronously on the second BUSY cycle.
        @(negedge clk);
        addr_in = 32'h200; inst_in = 32'h0000_2000; ip_in = 30'h123; wb_lines_in = 3'd5;
        mem_req_in = 1'b1; mem_we_in = 1'b0; clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        checkOutput("pre_rst_busy", 32'(bus_req), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("mid_rst_stall", 32'(stall), 32'd0);
        checkOutput("mid_rst_wb_data", wb_data, 32'd0);
        checkOutput("mid_rst_bus_addr", 32'(bus_addr), 32'd0);
        checkOutput("mid_rst_be", 32'(bus_be), 32'd0);
        checkOutput("mid_rst_wb_lines", 32'(wb_lines_out), 32'd0);
        checkOutput("mid_rst_ip", 32'(ip_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h300, 32'h0, 1, 1'b0, 1'b0, 1'b1, 2, 32'h0000F00D);

        for (int i = 0; i < 40; i++) begin
            size = int'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0 && size < 3) a = a & ~((32'd1 << size) - 1);
            dly = int'($urandom_range(0, 5));
            applyStimulus(a, $urandom, size, 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 4) != 0), dly, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255; maximum number of BUSY cycles waited for bus_ack before the access is abandoned (range 1-255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 clk_en  in  1  pipeline advance enable from execute.
REQ-005 mem_req_in / mem_we_in  in  1 each  memory access request / write (store) from execute.
REQ-006 addr_in  in  32  ALU result: effective address or plain result; wdata_in  in  32  store data.
REQ-007 inst_in  in  32  instruction word; ip_in  in  30  word IP; wb_lines_in  in  3  write-back control.
REQ-008 bus_req, bus_we  out  1 each; bus_addr  out  30  word address; bus_wdata  out  32; bus_be  out  4  byte enables.
REQ-009 bus_ack  in  1  access complete; bus_rdata  in  32  read data, valid with bus_ack.
REQ-010 stall  out  1  holds upstream stages while high.
REQ-011 wb_data  out  32; rd_addr  out  5 (= buffered inst[25:21]); wb_lines_out  out  3; ip_out  out  30; inst_out  out  32.
REQ-012 align_fault, bus_timeout  out  1 each  error flags for the buffered instruction.

Function
REQ-013 Input buffers (addr, wdata, inst, ip, wb_lines, mem_req, mem_we) capture on clk edge only when clk_en=1 and stall=0; otherwise they hold.
REQ-014 Size from inst[13:12]: 0 byte, 1 half, 2 word, 3 reserved; inst[14]=1 means zero-extend a load, 0 sign-extend.
REQ-015 Misaligned = half with addr[0]=1, word with addr[1:0]!=0, or size 3; evaluated on inputs at capture and registered as align_fault.
REQ-016 FSM states IDLE, BUSY; IDLE->BUSY on a capture with mem_req_in=1 and no misalignment; BUSY->IDLE on bus_ack or timeout.
REQ-017 A misaligned request never asserts bus_req; it forces wb_lines_out=0 while it occupies the stage.
REQ-018 bus_req=1 and stall=1 exactly while state=BUSY; bus_addr=addr[31:2], bus_we=buffered mem_we, both stable throughout BUSY.
REQ-019 Store lanes: byte -> wdata[7:0] replicated x4, be=1<<addr[1:0]; half -> wdata[15:0] replicated x2, be=addr[1]?1100:0011; word -> be=1111; loads drive be of the same pattern.
REQ-020 On bus_ack in BUSY, bus_rdata latches into a load register; lane selected by addr[1:0], extended per REQ-014.
REQ-021 wb_data = extended load register for a completed load, else buffered addr_in (ALU result, including stores and non-memory ops).
REQ-022 Timeout counter clears on IDLE->BUSY, increments each BUSY cycle without bus_ack; reaching TIMEOUT forces IDLE, sets bus_timeout, forces wb_lines_out=0 for that instruction.
REQ-023 bus_ack and timeout in the same cycle: ack wins, no bus_timeout.
REQ-024 bus_ack while IDLE is ignored.
REQ-025 align_fault and bus_timeout stay asserted until the next capture replaces the instruction.
REQ-026 rd_addr, ip_out, inst_out, wb_lines_out (unless forced 0) pass straight from the buffers.

Reset
REQ-027 rst=1 immediately forces state IDLE, bus_req=0, stall=0, all buffers, load register, counter and flags to 0, including mid-BUSY; no bus_ack is expected afterward.
REQ-028 After rst deassertion the first capture occurs on the first edge with clk_en=1.

Verification
REQ-029 Word load addr 0x100, bus_ack after 3 cycles with rdata 0xDEADBEEF -> bus_addr=0x40, be=1111, stall high 3 cycles, wb_data=0xDEADBEEF.
REQ-030 Signed byte load addr 0x103, rdata 0x80FFFFFF -> be=1000, wb_data=0xFFFFFF80; same with inst[14]=1 -> 0x00000080.
REQ-031 Half store addr 0x22 wdata 0x1234ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, wb_data=0x00000022.
REQ-032 Word load addr 0x102 -> align_fault=1, bus_req never asserted, stall=0, wb_lines_out=0.
REQ-033 TIMEOUT=4, no ack -> bus_req high 4 cycles, then IDLE, bus_timeout=1; ack on 4th cycle instead -> normal completion, bus_timeout=0.
REQ-034 rst pulsed on 2nd BUSY cycle -> bus_req and stall 0 asynchronously, all outputs 0; a later load completes normally.
